// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported memory bus between the hart's fetch and data ports.
// One hart step = optional data access, then the fetch, then a one-cycle
// ready pulse that returns both words together.
//
// state | meaning
// IDLE  | waiting for a fetch request; operands latched on exit
// D_REQ | data access on the bus (skipped when misaligned)
// I_REQ | instruction fetch on the bus
// DONE  | ready pulse for both ports, bus_err if anything went wrong
module riscv_mem_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_addr_valid,
  input  logic [31:0] i_addr,
  output logic        i_data_ready,
  output logic [31:0] i_data,
  input  logic [2:0]  d_mem_op,
  input  logic        d_addr_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write_data_valid,
  input  logic [31:0] d_write_data,
  output logic        d_read_data_ready,
  output logic [31:0] d_read_data,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, D_REQ, I_REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q;
  logic [31:0]       i_addr_q, d_addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic              we_q, err_q;
  logic              rdy;

  // Sign-extension choice and fetch offset bits are the hart's concern only.
  logic unused_bits;
  assign unused_bits = ^{i_addr[1:0], d_mem_op[2]};

  // d_mem_op[1:0]: 00 byte, 01 half, 1x word (covers the undefined codes 3/6/7).
  logic [1:0]  size;
  logic        misaligned;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic        to_hit;

  assign size       = d_mem_op[1:0];
  assign misaligned = d_addr_valid &&
                      (((size == 2'b01) && d_addr[0]) || (size[1] && (d_addr[1:0] != 2'b00)));
  // Abandon on the cycle whose count would reach TIMEOUT-1 without an ack.
  assign to_hit     = !mem_ack && (cnt_q == TO_W'(TIMEOUT - 2));

  // Store lane alignment: strobes select the lanes, data is replicated so any lane is correct.
  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = d_write_data;
    case (size)
      2'b00: begin
        strb_new  = 4'b0001 << d_addr[1:0];
        wdata_new = {4{d_write_data[7:0]}};
      end
      2'b01: begin
        strb_new  = d_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{d_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state and bus outputs; bus fields come from latched operands so they stay stable.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    rdy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_addr_valid) state_d = (d_addr_valid && !misaligned) ? D_REQ : I_REQ;
      end
      D_REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = d_addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if (mem_ack || to_hit) state_d = I_REQ;
      end
      I_REQ: begin
        mem_req  = 1'b1;
        mem_addr = i_addr_q;
        if (mem_ack || to_hit) state_d = DONE;
      end
      DONE: begin
        rdy     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_data_ready      = rdy;
  assign d_read_data_ready = rdy;
  assign bus_err           = rdy && err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, result capture, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      i_addr_q    <= 32'h0;
      d_addr_q    <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      i_data      <= 32'h0;
      d_read_data <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_addr_valid) begin
            i_addr_q    <= {i_addr[31:2], 2'b00};
            d_addr_q    <= {d_addr[31:2], 2'b00};
            we_q        <= d_write_data_valid;
            wdata_q     <= d_write_data_valid ? wdata_new : 32'h0;
            wstrb_q     <= d_write_data_valid ? strb_new : 4'h0;
            err_q       <= misaligned;
            i_data      <= 32'h0;
            d_read_data <= 32'h0;
            cnt_q       <= '0;
          end
        end
        D_REQ: begin
          if (mem_ack) begin
            if (!we_q) d_read_data <= mem_rdata;
            cnt_q <= '0;
          end else if (to_hit) begin
            d_read_data <= 32'h0;
            err_q       <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        I_REQ: begin
          if (mem_ack) begin
            i_data <= mem_rdata;
            cnt_q  <= '0;
          end else if (to_hit) begin
            i_data <= 32'h0;
            err_q  <= 1'b1;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench: expected bus transactions and step results are queued as
// each step is driven, then popped when the bus request / ready pulse appears.
module tb_riscv_mem_arbiter;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_addr_valid = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_data_ready;
  logic [31:0] i_data;
  logic [2:0]  d_mem_op = 3'd0;
  logic        d_addr_valid = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic        d_write_data_valid = 1'b0;
  logic [31:0] d_write_data = 32'h0;
  logic        d_read_data_ready;
  logic [31:0] d_read_data;
  logic        bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  riscv_mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr_valid(i_addr_valid), .i_addr(i_addr),
    .i_data_ready(i_data_ready), .i_data(i_data),
    .d_mem_op(d_mem_op), .d_addr_valid(d_addr_valid), .d_addr(d_addr),
    .d_write_data_valid(d_write_data_valid), .d_write_data(d_write_data),
    .d_read_data_ready(d_read_data_ready), .d_read_data(d_read_data),
    .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] d;
    logic        err;
    logic [31:0] lat;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   tests = 0;
  int   fails = 0;
  int   waits = 0;
  logic noack = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus responder: checks each new request against the queue, acks after `waits` cycles.
  initial begin : responder
    int   wcnt;
    logic fresh;
    bus_t e;
    wcnt  = 0;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (fresh) begin
          fresh = 1'b0;
          if (bus_q.size() == 0) begin
            chk("bus_unexpected", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = bus_q.pop_front();
            chk("bus_we", {31'h0, mem_we}, {31'h0, e.we});
            chk("bus_addr", mem_addr, e.addr);
            chk("bus_wdata", mem_wdata, e.wdata);
            chk("bus_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
          end
        end
        if (!noack && wcnt == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = rd(mem_addr);
          wcnt      = 0;
          fresh     = 1'b1;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
        fresh   = 1'b1;
      end
    end
  end

  // One hart step, called right after a falling edge.
  task automatic do_step(input logic [31:0] ia, input logic dv, input logic [31:0] da,
                         input logic [2:0] op, input logic st, input logic [31:0] wd,
                         input int w, input logic na);
    logic        mis, diss, seen;
    logic [3:0]  strb;
    logic [31:0] wdat;
    int          ph, n;
    bus_t        b;
    res_t        r, got;
    mis  = dv && (((op[1:0] == 2'b01) && da[0]) || (op[1] && (da[1:0] != 2'b00)));
    diss = dv && !mis;
    case (op[1:0])
      2'b00:   begin strb = 4'b0001 << da[1:0]; wdat = {4{wd[7:0]}}; end
      2'b01:   begin strb = da[1] ? 4'b1100 : 4'b0011; wdat = {2{wd[15:0]}}; end
      default: begin strb = 4'b1111; wdat = wd; end
    endcase
    if (!st) begin strb = 4'h0; wdat = 32'h0; end
    if (diss) begin
      b = '{we: st, addr: {da[31:2], 2'b00}, wdata: wdat, wstrb: strb};
      bus_q.push_back(b);
    end
    b = '{we: 1'b0, addr: ia, wdata: 32'h0, wstrb: 4'h0};
    bus_q.push_back(b);
    ph    = na ? TIMEOUT - 1 : w + 1;
    r.i   = na ? 32'h0 : rd(ia);
    r.d   = (diss && !st && !na) ? rd({da[31:2], 2'b00}) : 32'h0;
    r.err = mis || na;
    r.lat = 32'((diss ? ph : 0) + ph + 1);
    res_q.push_back(r);
    waits = w;
    noack = na;
    i_addr_valid       = 1'b1;
    i_addr             = ia;
    d_addr_valid       = dv;
    d_addr             = da;
    d_mem_op           = op;
    d_write_data_valid = st;
    d_write_data       = wd;
    n    = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(negedge clk);
      n++;
      i_addr_valid = 1'b0;
      if (i_data_ready) seen = 1'b1;
    end
    got = res_q.pop_front();
    chk("ready_seen", {31'h0, seen}, 32'h1);
    chk("latency", 32'(n), got.lat);
    chk("i_data", i_data, got.i);
    chk("d_read_data", d_read_data, got.d);
    chk("d_ready", {31'h0, d_read_data_ready}, 32'h1);
    chk("bus_err", {31'h0, bus_err}, {31'h0, got.err});
    d_addr_valid       = 1'b0;
    d_write_data_valid = 1'b0;
    @(negedge clk);
    chk("ready_pulse", {31'h0, i_data_ready}, 32'h0);
    chk("err_pulse", {31'h0, bus_err}, 32'h0);
    noack = 1'b0;
  endtask

  initial begin
    bus_t b;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ready", {31'h0, i_data_ready}, 32'h0);
    chk("rst_i_data", i_data, 32'h0);
    chk("rst_d_data", d_read_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_step(32'h100, 1'b0, 32'h0,    3'd0, 1'b0, 32'h0,        0, 1'b0); // fetch only
    do_step(32'h104, 1'b1, 32'h2004, 3'd2, 1'b0, 32'h0,        2, 1'b0); // LW + fetch, 2 waits
    do_step(32'h108, 1'b1, 32'h3003, 3'd0, 1'b1, 32'h0000_00AB, 0, 1'b0); // SB lane 3
    do_step(32'h10C, 1'b1, 32'h4001, 3'd1, 1'b0, 32'h0,        0, 1'b0); // misaligned LH
    do_step(32'h110, 1'b1, 32'h5002, 3'd1, 1'b1, 32'h1234_BEEF, 0, 1'b0); // SH upper half
    do_step(32'h114, 1'b1, 32'h6008, 3'd2, 1'b1, 32'hCAFE_F00D, 1, 1'b0); // SW, 1 wait
    do_step(32'h118, 1'b1, 32'h7002, 3'd7, 1'b0, 32'h0,        0, 1'b0); // op 7 as W, misaligned
    do_step(32'h11C, 1'b1, 32'h8001, 3'd4, 1'b0, 32'h0,        1, 1'b0); // LBU
    do_step(32'h120, 1'b1, 32'h9001, 3'd0, 1'b1, 32'h0000_0055, 0, 1'b0); // SB lane 1
    do_step(32'h124, 1'b0, 32'h0,    3'd0, 1'b0, 32'h0,        0, 1'b1); // fetch timeout

    // Reset while a load waits on the bus.
    b = '{we: 1'b0, addr: 32'hA000, wdata: 32'h0, wstrb: 4'h0};
    bus_q.push_back(b);
    waits = 5;
    i_addr_valid = 1'b1; i_addr = 32'h128;
    d_addr_valid = 1'b1; d_addr = 32'hA000; d_mem_op = 3'd2; d_write_data_valid = 1'b0;
    @(negedge clk);
    i_addr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_ready", {31'h0, i_data_ready}, 32'h0);
    chk("mid_rst_err", {31'h0, bus_err}, 32'h0);
    d_addr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_step(32'h12C, 1'b1, 32'hB004, 3'd2, 1'b0, 32'h0,        0, 1'b0); // clean restart

    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
